// File: rtl/wb_pkg.sv
// wb_pkg: shared register-file widths and the writeback entry type
package wb_pkg;
  localparam int REG_ADDR_W = 3;
  localparam int REG_DATA_W = 8;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: two-entry FIFO holding load results waiting for a writeback slot
module wb_fifo
  import wb_pkg::*;
(
  input  logic      clk_i,
  input  logic      reset_i,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t din,
  output wb_entry_t dout,
  output logic      full,
  output logic      empty
);
  wb_entry_t  mem [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] count;
  assign full  = count == 2'd2;
  assign empty = count == 2'd0;
  assign dout  = mem[rd_ptr];
  // pointers and occupancy; reset empties the queue without touching payload storage
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      rd_ptr <= rd_ptr ^ pop;
      wr_ptr <= wr_ptr ^ push;
      count  <= count + {1'b0, push} - {1'b0, pop};
    end
  // payload storage, written at the tail slot
  always_ff @(posedge clk_i)
    if (push) mem[wr_ptr] <= din;
endmodule

// File: rtl/wb_stage.sv
// wb_stage: arbitrates ALU and queued load results onto the register-file write port (WB_FWD_EN enables operand forwarding)
module wb_stage
  import wb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  alu_valid_i,
  output logic                  alu_ready_o,
  input  logic [REG_ADDR_W-1:0] alu_addr_i,
  input  logic [REG_DATA_W-1:0] alu_data_i,
  input  logic                  mem_valid_i,
  output logic                  mem_ready_o,
  input  logic [REG_ADDR_W-1:0] mem_addr_i,
  input  logic [REG_DATA_W-1:0] mem_data_i,
  output logic                  write_o,
  output logic [REG_ADDR_W-1:0] write_addr_o,
  output logic [REG_DATA_W-1:0] write_data_o,
  input  logic [REG_ADDR_W-1:0] rs_addr_i,
  input  logic [REG_ADDR_W-1:0] rt_addr_i,
  output logic                  rs_fwd_o,
  output logic                  rt_fwd_o
);
  logic [3:0] starve;
  logic       alu_fire;
  logic       push;
  logic       pop;
  logic       full;
  logic       empty;
  wb_entry_t  head;
  assign alu_ready_o = reset_i && (starve != 4'(STARVE_LIMIT));
  assign mem_ready_o = reset_i && !full;
  assign alu_fire    = alu_valid_i && alu_ready_o;
  assign push        = mem_valid_i && mem_ready_o;
  assign pop         = !alu_fire && !empty;
  wb_fifo u_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .push   (push),
    .pop    (pop),
    .din    ('{addr: mem_addr_i, data: mem_data_i}),
    .dout   (head),
    .full   (full),
    .empty  (empty)
  );
  // count ALU wins that bypass a waiting load; any other cycle clears it
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) starve <= 4'd0;
    else          starve <= (alu_fire && !empty) ? starve + 4'd1 : 4'd0;
  // register the selected result: ALU first, else oldest queued load
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      write_o      <= 1'b0;
      write_addr_o <= '0;
      write_data_o <= '0;
    end else begin
      write_o      <= alu_fire || pop;
      write_addr_o <= alu_fire ? alu_addr_i : head.addr;
      write_data_o <= alu_fire ? alu_data_i : head.data;
    end
`ifdef WB_FWD_EN
  assign rs_fwd_o = write_o && (write_addr_o == rs_addr_i);
  assign rt_fwd_o = write_o && (write_addr_o == rt_addr_i);
`else
  logic unused_fwd;
  assign unused_fwd = ^{rs_addr_i, rt_addr_i};
  assign rs_fwd_o   = 1'b0;
  assign rt_fwd_o   = 1'b0;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed vector table plus reset sequences for wb_stage
module tb_wb_stage;
  logic       clk;
  logic       rst_n;
  logic       alu_valid;
  logic       alu_ready;
  logic [2:0] alu_addr;
  logic [7:0] alu_data;
  logic       mem_valid;
  logic       mem_ready;
  logic [2:0] mem_addr;
  logic [7:0] mem_data;
  logic       wr;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [2:0] rs_addr;
  logic [2:0] rt_addr;
  logic       rs_fwd;
  logic       rt_fwd;
  int         total;
  int         bad;
`ifdef WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  wb_stage #(.STARVE_LIMIT(4)) dut (
    .clk_i       (clk),
    .reset_i     (rst_n),
    .alu_valid_i (alu_valid),
    .alu_ready_o (alu_ready),
    .alu_addr_i  (alu_addr),
    .alu_data_i  (alu_data),
    .mem_valid_i (mem_valid),
    .mem_ready_o (mem_ready),
    .mem_addr_i  (mem_addr),
    .mem_data_i  (mem_data),
    .write_o     (wr),
    .write_addr_o(wr_addr),
    .write_data_o(wr_data),
    .rs_addr_i   (rs_addr),
    .rt_addr_i   (rt_addr),
    .rs_fwd_o    (rs_fwd),
    .rt_fwd_o    (rt_fwd)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {
    logic       av;
    logic [2:0] aa;
    logic [7:0] ad;
    logic       mv;
    logic [2:0] ma;
    logic [7:0] md;
    logic [2:0] rs;
    logic [2:0] rt;
    logic       ar;
    logic       mr;
    logic       w;
    logic [2:0] wa;
    logic [7:0] wd;
    logic       rf;
    logic       tf;
  } vec_t;
  vec_t vt [20];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic av, input logic [2:0] aa, input logic [7:0] ad,
                       input logic mv, input logic [2:0] ma, input logic [7:0] md);
    alu_valid = av;
    alu_addr  = aa;
    alu_data  = ad;
    mem_valid = mv;
    mem_addr  = ma;
    mem_data  = md;
  endtask
  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    rs_addr = 3'd0;
    rt_addr = 3'd0;
    //        av    aa    ad     mv    ma    md     rs    rt    ar    mr    w     wa    wd     rf    tf
    vt[0]  = '{1'b1, 3'd3, 8'h5a, 1'b0, 3'd0, 8'h00, 3'd3, 3'd4, 1'b1, 1'b1, 1'b1, 3'd3, 8'h5a, 1'b1, 1'b0};
    vt[1]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 3'd2, 3'd4, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 8'h11, 3'd5, 3'd4, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 3'd5, 3'd5, 1'b1, 1'b1, 1'b1, 3'd5, 8'h11, 1'b1, 1'b1};
    vt[4]  = '{1'b1, 3'd2, 8'h22, 1'b0, 3'd0, 8'h00, 3'd2, 3'd4, 1'b1, 1'b1, 1'b1, 3'd2, 8'h22, 1'b1, 1'b0};
    vt[5]  = '{1'b1, 3'd1, 8'h01, 1'b1, 3'd6, 8'h61, 3'd0, 3'd0, 1'b1, 1'b1, 1'b1, 3'd1, 8'h01, 1'b0, 1'b0};
    vt[6]  = '{1'b1, 3'd1, 8'h02, 1'b1, 3'd6, 8'h62, 3'd0, 3'd0, 1'b1, 1'b1, 1'b1, 3'd1, 8'h02, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 3'd1, 8'h03, 1'b1, 3'd7, 8'h63, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 3'd1, 8'h03, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd7, 8'h63, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 3'd6, 8'h61, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd7, 8'h63, 3'd0, 3'd0, 1'b1, 1'b1, 1'b1, 3'd6, 8'h62, 1'b0, 1'b0};
    vt[10] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 3'd7, 3'd0, 1'b1, 1'b1, 1'b1, 3'd7, 8'h63, 1'b1, 1'b0};
    vt[11] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0};
    vt[12] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 8'h44, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0};
    vt[13] = '{1'b1, 3'd0, 8'ha0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd4, 1'b1, 1'b1, 1'b1, 3'd0, 8'ha0, 1'b1, 1'b0};
    vt[14] = '{1'b1, 3'd0, 8'ha1, 1'b0, 3'd0, 8'h00, 3'd0, 3'd4, 1'b1, 1'b1, 1'b1, 3'd0, 8'ha1, 1'b1, 1'b0};
    vt[15] = '{1'b1, 3'd0, 8'ha2, 1'b0, 3'd0, 8'h00, 3'd0, 3'd4, 1'b1, 1'b1, 1'b1, 3'd0, 8'ha2, 1'b1, 1'b0};
    vt[16] = '{1'b1, 3'd0, 8'ha3, 1'b0, 3'd0, 8'h00, 3'd0, 3'd4, 1'b1, 1'b1, 1'b1, 3'd0, 8'ha3, 1'b1, 1'b0};
    vt[17] = '{1'b1, 3'd0, 8'ha4, 1'b0, 3'd0, 8'h00, 3'd0, 3'd4, 1'b0, 1'b1, 1'b1, 3'd4, 8'h44, 1'b0, 1'b1};
    vt[18] = '{1'b1, 3'd0, 8'ha4, 1'b0, 3'd0, 8'h00, 3'd0, 3'd4, 1'b1, 1'b1, 1'b1, 3'd0, 8'ha4, 1'b1, 1'b0};
    vt[19] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 3'd0, 3'd4, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0};
    tick();
    tick();
    chk("rst_write", {31'd0, wr}, 32'd0);
    chk("rst_addr", {29'd0, wr_addr}, 32'd0);
    chk("rst_data", {24'd0, wr_data}, 32'd0);
    chk("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
    chk("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
    chk("rst_fwd", {30'd0, rs_fwd, rt_fwd}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_alu_ready", {31'd0, alu_ready}, 32'd1);
    chk("post_rst_mem_ready", {31'd0, mem_ready}, 32'd1);
    tick();
    for (int i = 0; i < 20; i++) begin
      drive(vt[i].av, vt[i].aa, vt[i].ad, vt[i].mv, vt[i].ma, vt[i].md);
      rs_addr = vt[i].rs;
      rt_addr = vt[i].rt;
      #1;
      chk($sformatf("v%0d_alu_ready", i), {31'd0, alu_ready}, {31'd0, vt[i].ar});
      chk($sformatf("v%0d_mem_ready", i), {31'd0, mem_ready}, {31'd0, vt[i].mr});
      tick();
      chk($sformatf("v%0d_write", i), {31'd0, wr}, {31'd0, vt[i].w});
      if (vt[i].w) begin
        chk($sformatf("v%0d_addr", i), {29'd0, wr_addr}, {29'd0, vt[i].wa});
        chk($sformatf("v%0d_data", i), {24'd0, wr_data}, {24'd0, vt[i].wd});
      end
      chk($sformatf("v%0d_rs_fwd", i), {31'd0, rs_fwd}, {31'd0, vt[i].rf & FWD});
      chk($sformatf("v%0d_rt_fwd", i), {31'd0, rt_fwd}, {31'd0, vt[i].tf & FWD});
    end
    drive(1'b1, 3'd1, 8'h10, 1'b1, 3'd2, 8'h20);
    tick();
    drive(1'b1, 3'd1, 8'h11, 1'b1, 3'd3, 8'h30);
    tick();
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    rs_addr = 3'd1;
    rt_addr = 3'd1;
    #1;
    chk("q2_full", {31'd0, mem_ready}, 32'd0);
    chk("q2_write", {31'd0, wr}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_write", {31'd0, wr}, 32'd0);
    chk("mid_rst_addr", {29'd0, wr_addr}, 32'd0);
    chk("mid_rst_data", {24'd0, wr_data}, 32'd0);
    chk("mid_rst_alu_ready", {31'd0, alu_ready}, 32'd0);
    chk("mid_rst_mem_ready", {31'd0, mem_ready}, 32'd0);
    chk("mid_rst_fwd", {30'd0, rs_fwd, rt_fwd}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rel_alu_ready", {31'd0, alu_ready}, 32'd1);
    chk("rel_mem_ready", {31'd0, mem_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("stale_write%0d", i), {31'd0, wr}, 32'd0);
    end
    drive(1'b1, 3'd6, 8'hc3, 1'b0, 3'd0, 8'h00);
    tick();
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    chk("after_rst_write", {31'd0, wr}, 32'd1);
    chk("after_rst_data", {24'd0, wr_data}, 32'hc3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter: STARVE_LIMIT, 4, number of consecutive ALU wins while memory results wait (range 1..15).
REQ-002 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_i  input  1  asynchronous, active-low reset.
REQ-004 alu_valid_i  input  1  ALU result present this cycle.
REQ-005 alu_ready_o  output  1  stage accepts ALU result this cycle.
REQ-006 alu_addr_i  input  3  destination register of ALU result.
REQ-007 alu_data_i  input  8  ALU result value.
REQ-008 mem_valid_i  input  1  load result present this cycle.
REQ-009 mem_ready_o  output  1  stage accepts load result this cycle.
REQ-010 mem_addr_i  input  3  destination register of load result.
REQ-011 mem_data_i  input  8  load result value.
REQ-012 write_o  output  1  register-file write enable.
REQ-013 write_addr_o  output  3  register-file write address.
REQ-014 write_data_o  output  8  register-file write data.
REQ-015 rs_addr_i, rt_addr_i  input  3 each  operand addresses being read from the register file.
REQ-016 rs_fwd_o, rt_fwd_o  output  1 each  forward select: use write_data_o instead of register-file data.

Function
REQ-017 ALU transfer occurs when alu_valid_i && alu_ready_o; memory transfer when mem_valid_i && mem_ready_o.
REQ-018 Load results SHALL enter a 2-entry FIFO; mem_ready_o = FIFO not full, from registered state only (no same-cycle pop bypass).
REQ-019 Per cycle, ALU transfer has priority; otherwise a non-empty FIFO pops its oldest entry; otherwise no write is selected.
REQ-020 Selected result SHALL be registered: write_o/write_addr_o/write_data_o valid the cycle after selection; write_o low when nothing selected.
REQ-021 Latency: ALU accepted in cycle N -> write_o in N+1; load accepted in N -> earliest write_o in N+2.
REQ-022 Results to the register file SHALL preserve per-source order; ALU and load streams are not reordered relative to themselves.
REQ-023 Starvation counter (4 bits) increments each cycle an ALU transfer occurs while FIFO non-empty; clears when FIFO pops or is empty.
REQ-024 alu_ready_o = (counter != STARVE_LIMIT), from registers; at limit the FIFO pops that cycle and counter clears.
REQ-025 Push and pop in same cycle with FIFO holding 1 entry: occupancy stays 1, new entry becomes oldest next cycle.
REQ-026 Push while full never occurs (mem_ready_o low); mem_valid_i without ready is held by the producer, not dropped.
REQ-027 rs_fwd_o = write_o && (write_addr_o == rs_addr_i); rt_fwd_o likewise; combinational.

Reset
REQ-028 While reset_i low: write_o=0, write_addr_o=0, write_data_o=0, FIFO empty, counter=0, alu_ready_o=0, mem_ready_o=0, fwd outputs 0.
REQ-029 First cycle after deassertion: alu_ready_o=1, mem_ready_o=1; reset mid-operation discards all queued loads.

Configuration
REQ-030 Macro WB_FWD_EN defined: REQ-027 forwarding logic present.
REQ-031 WB_FWD_EN undefined: rs_fwd_o and rt_fwd_o tied 0, ports retained, no compare logic.

Structure
REQ-032 Shared package holds REG_ADDR_W=3, REG_DATA_W=8 and wb_entry_t (addr, data) typedef.
REQ-033 FIFO SHALL be a sub-module wb_fifo (depth 2, wb_entry_t payload, push/pop/full/empty).

Verification
REQ-034 Reset then ALU valid addr=3 data=0x5A -> next cycle write_o=1, addr=3, data=0x5A.
REQ-035 Load addr=5 data=0x11 with ALU idle -> write_o two cycles later with addr=5, data=0x11.
REQ-036 Three loads back-to-back, ALU busy -> mem_ready_o low after second accept; third held, all three written in order.
REQ-037 ALU valid every cycle with one queued load, STARVE_LIMIT=4 -> alu_ready_o low on 5th cycle, load written next cycle, alu_ready_o high after.
REQ-038 write_o=1 addr=2, rs_addr_i=2, rt_addr_i=4 -> rs_fwd_o=1, rt_fwd_o=0 (WB_FWD_EN); both 0 without macro.
REQ-039 Assert reset_i low with two queued loads -> outputs cleared immediately; after release, no stale writes appear.
